mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
Shares the single-port, initialize-on-reset 32-bit data memory between the multicycle core's instruction-fetch port (read-only) and data port (load/store). Each access is one outstanding transaction through an IDLE/ACCESS/WAIT/DONE state machine with uniform latency. Requests are held off until the memory's post-reset initialization completes. Sits between the core control unit and the memory wrapper.

Parameters:
READ_LATENCY, 1, memory clock edges from the ACCESS cycle until mem_q is valid (1..4).
INIT_GUARD, 2, minimum cycles spent in INIT after reset before mem_busy is trusted (>=2).

Ports:
clock  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset; also drives the memory wrapper's rst.
mem_busy  in  1  memory wrapper rdy output; high while initialization runs.
mem_address  out  16  byte address to memory; bits [1:0] always 0.
mem_data  out  32  write data to memory.
mem_wren  out  1  memory write enable.
mem_q  in  32  memory read data.
if_req  in  1  fetch request; held with if_addr until if_ack.
if_addr  in  16  fetch byte address.
if_ack  out  1  one-cycle completion pulse; if_rdata valid in the same cycle.
if_rdata  out  32  fetched word; held until the next if_ack.
d_req  in  1  data request; held with d_wren, d_addr and d_wdata until d_ack.
d_wren  in  1  1 = store, 0 = load.
d_addr  in  16  data byte address.
d_wdata  in  32  store data.
d_ack  out  1  one-cycle completion pulse, for loads and stores.
d_rdata  out  32  loaded word; held until the next load ack. Not updated by stores.
ready  out  1  high whenever state is not INIT.

Behaviour:
- Reset (any state, mid-transaction included) sets all of the following; any in-flight request is dropped and must be re-presented:
  - state = INIT, guard counter = 0, grant = none.
  - mem_address, mem_data, if_rdata and d_rdata = 0.
  - mem_wren, if_ack, d_ack and ready = 0.
- INIT:
  - Counter increments each cycle.
  - Go to IDLE when counter >= INIT_GUARD-1 and mem_busy = 0.
  - Requests are ignored while in INIT.
- IDLE:
  - No request when mem_busy = 1 or no req is high; stay in IDLE.
  - Otherwise choose a winner and register mem_address = {addr[15:2], 2'b00}.
  - Register mem_data = d_wdata and mem_wren = d_wren for a data grant, mem_wren = 0 for a fetch grant.
  - Go to ACCESS.
- Conflict (both req high in IDLE): data port wins, unless the optional feature is enabled.
- ACCESS:
  - Memory inputs are stable for exactly one cycle.
  - Next cycle: mem_wren = 0, wait counter loads READ_LATENCY, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, capture mem_q into the winner's rdata, except for stores; go to DONE.
- DONE:
  - Winner's ack = 1 for exactly this cycle; go to IDLE.
- Latency: req sampled in cycle 0 -> ack in cycle 2+READ_LATENCY (cycle 3 at default). Loads and stores have the same latency.
- Requester protocol:
  - A req still high in the cycle after its ack is a new request.
  - Changing addr or data while req is high and before ack is illegal; the arbiter uses the values sampled in IDLE.
- Losing requester: keeps req high and is served at the next IDLE. Back-to-back service gives one IDLE cycle between transactions.
- mem_busy rising outside INIT/IDLE: ignored until the next IDLE.
- Addresses: bits [1:0] are discarded (word aligned). A 16-bit wrap from 0xFFFC is a normal access.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined:
  - On a conflict the winner is the port not granted last.
  - Last-grant register resets to "data", so the first conflict after reset goes to fetch.
  - Last-grant updates on every grant, including uncontested ones.
- Undefined: fixed priority, data port always wins conflicts; no last-grant register.

Test Plan:
- Reset, memory initialization: pulse rst, hold mem_busy = 1 for 20 cycles, then 0 -> ready = 0 throughout; ready = 1 one cycle after mem_busy falls (never before INIT_GUARD); if_req raised during init is not acked until after ready.
- Single fetch, READ_LATENCY = 1: if_req = 1, if_addr = 0x0013 -> mem_address = 0x0010 in cycle 1 with mem_wren = 0; if_ack in cycle 3; if_rdata = mem_q word at 0x0010.
- Store then load: store d_addr = 0x0040, d_wdata = 0xDEADBEEF -> mem_wren = 1 for exactly one cycle, d_ack in cycle 3, d_rdata unchanged; load from 0x0040 -> d_rdata = 0xDEADBEEF.
- Conflict: if_req and d_req both high in the same cycle, repeated 4 times -> without macro, data is served first in every pair; with ARB_ROUND_ROBIN_EN the first winner is fetch, then grants alternate; the loser is served next with one IDLE gap.
- Reset mid-transaction: assert rst in the WAIT cycle of a load -> no d_ack; mem_wren = 0; state INIT; after the re-init completes, the re-presented request completes normally.
- READ_LATENCY = 3: single load -> ack in cycle 5; rdata equals mem_q sampled in the last WAIT cycle.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares one single-port 32-bit data memory between the core's instruction
// fetch port (read-only) and its data port (load/store). Each access is a
// single outstanding transaction that walks INIT/IDLE/ACCESS/WAIT/DONE with a
// uniform latency of 2+READ_LATENCY cycles from the sampling IDLE cycle to the
// ack. No request is accepted until the memory's post-reset initialization
// has finished.
//
// Parameters:
//   READ_LATENCY  memory clock edges from the ACCESS cycle to valid mem_q (1..4)
//   INIT_GUARD    minimum cycles spent in INIT before mem_busy is trusted (>=2)
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  when defined, a conflict goes to the port that was not
//                       granted last. When undefined, the data port always
//                       wins a conflict.
//
// Ports:
//   clock        system clock, all logic on posedge
//   rst          synchronous active-high reset (also resets the memory wrapper)
//   mem_busy     memory wrapper busy flag, high while it initializes
//   mem_address  word-aligned byte address to memory
//   mem_data     write data to memory
//   mem_wren     memory write enable, high for the single ACCESS cycle of a store
//   mem_q        memory read data
//   if_req       fetch request, held with if_addr until if_ack
//   if_addr      fetch byte address
//   if_ack       one-cycle fetch completion pulse
//   if_rdata     fetched word, held until the next if_ack
//   d_req        data request, held with d_wren/d_addr/d_wdata until d_ack
//   d_wren       1 = store, 0 = load
//   d_addr       data byte address
//   d_wdata      store data
//   d_ack        one-cycle data completion pulse (loads and stores)
//   d_rdata      loaded word, held until the next load ack
//   ready        high whenever the arbiter has left INIT
// ---------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int INIT_GUARD   = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        mem_busy,
  output logic [15:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wren,
  input  logic [15:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        ready
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  // The guard counter only has to reach INIT_GUARD-1; it saturates there so a
  // long initialization can never wrap it back below the threshold.
  localparam int               GUARD_W    = $clog2(INIT_GUARD) + 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(INIT_GUARD - 1);
  localparam logic [2:0]       WAIT_LOAD  = 3'(READ_LATENCY);

  state_t             state;
  grant_t             grant;
  logic [GUARD_W-1:0] guard_cnt;
  logic [2:0]         wait_cnt;
  logic               store_op;   // current data grant is a store
  logic               pick_data;  // data port wins the grant decided this cycle

  // The two low address bits are dropped by word alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  grant_t last_grant;
`endif

  // Winner selection. Only consulted in IDLE when at least one req is high.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    pick_data = d_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (d_req && if_req) begin
      pick_data = (last_grant == GNT_FETCH);
    end
`endif
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others; reset is sampled on the clock
  // edge, which makes it synchronous.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= ST_INIT;
      grant       <= GNT_NONE;
      guard_cnt   <= '0;
      wait_cnt    <= '0;
      store_op    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      ready       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= GNT_DATA;
`endif
    end else begin
      // Acks are single-cycle pulses; only the WAIT->DONE transition sets one.
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      case (state)
        ST_INIT: begin
          if (guard_cnt != GUARD_LAST) begin
            guard_cnt <= guard_cnt + 1'b1;
          end
          // mem_busy is only trusted once the guard time has elapsed, since
          // the wrapper may not have raised it yet right after reset.
          if ((guard_cnt >= GUARD_LAST) && !mem_busy) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end

        ST_IDLE: begin
          if (!mem_busy && (if_req || d_req)) begin
            if (pick_data) begin
              grant       <= GNT_DATA;
              mem_address <= {d_addr[15:2], 2'b00};
              mem_data    <= d_wdata;
              mem_wren    <= d_wren;
              store_op    <= d_wren;
`ifdef ARB_ROUND_ROBIN_EN
              last_grant  <= GNT_DATA;
`endif
            end else begin
              // mem_data is left as-is for a fetch; it is don't-care when
              // mem_wren is low.
              grant       <= GNT_FETCH;
              mem_address <= {if_addr[15:2], 2'b00};
              mem_wren    <= 1'b0;
              store_op    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
              last_grant  <= GNT_FETCH;
`endif
            end
            state <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // Memory inputs were presented for exactly this one cycle.
          mem_wren <= 1'b0;
          wait_cnt <= WAIT_LOAD;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          // With the counter loaded to READ_LATENCY on the ACCESS edge, the
          // cycle where it reads 1 is the first one with mem_q valid.
          if (wait_cnt == 3'd1) begin
            if (grant == GNT_FETCH) begin
              if_rdata <= mem_q;
              if_ack   <= 1'b1;
            end else begin
              if (!store_op) begin
                d_rdata <= mem_q;
              end
              d_ack <= 1'b1;
            end
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Ack is high during this cycle; the next IDLE gives the requester
          // one cycle to drop or re-present its req.
          grant <= GNT_NONE;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_access_arbiter
//
// Scoreboard bench for mem_access_arbiter. Stimulus pushes the expected ack
// (port, cycle, read data) into a queue; a negedge monitor pops and compares
// whenever an ack appears. A second instance with READ_LATENCY = 3 covers the
// longer latency. Both instances talk to small behavioural memory models.
// ---------------------------------------------------------------------------
module tb_mem_access_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam bit P_FETCH = 1'b0;
  localparam bit P_DATA  = 1'b1;

  typedef struct {
    bit          port;
    int          cyc;
    logic [31:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (READ_LATENCY = 1)
  logic        rst, mem_busy;
  logic [15:0] mem_address;
  logic [31:0] mem_data, mem_q;
  logic        mem_wren;
  logic        if_req, if_ack;
  logic [15:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_wren, d_ack;
  logic [15:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        ready;

  // Second instance (READ_LATENCY = 3)
  logic [15:0] m3_address;
  logic [31:0] m3_data, m3_q;
  logic        m3_wren;
  logic        i3_req, i3_ack;
  logic [15:0] i3_addr;
  logic [31:0] i3_rdata;
  logic        d3_req, d3_wren, d3_ack;
  logic [15:0] d3_addr;
  logic [31:0] d3_wdata, d3_rdata;
  logic        ready3;

  mem_access_arbiter #(.READ_LATENCY(LAT), .INIT_GUARD(2)) u_dut (
    .clock(clock), .rst(rst), .mem_busy(mem_busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .ready(ready)
  );

  mem_access_arbiter #(.READ_LATENCY(LAT3), .INIT_GUARD(2)) u_dut3 (
    .clock(clock), .rst(rst), .mem_busy(mem_busy),
    .mem_address(m3_address), .mem_data(m3_data), .mem_wren(m3_wren), .mem_q(m3_q),
    .if_req(i3_req), .if_addr(i3_addr), .if_ack(i3_ack), .if_rdata(i3_rdata),
    .d_req(d3_req), .d_wren(d3_wren), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_ack(d3_ack), .d_rdata(d3_rdata), .ready(ready3)
  );

  // Unwritten words read back as C0DE followed by the word index.
  function automatic logic [31:0] pattern(input logic [15:0] a);
    return {16'hC0DE, 2'b00, a[15:2]};
  endfunction

  // Memory model for the main instance, one-edge read latency. Contents are
  // kept across rst; the arbiter does not depend on them.
  bit   [31:0] mem_wr_data [0:16383];
  bit          mem_wr_flag [0:16383];
  logic [31:0] q_reg;
  always @(posedge clock) begin
    if (mem_wren === 1'b1) begin
      mem_wr_data[mem_address[15:2]] <= mem_data;
      mem_wr_flag[mem_address[15:2]] <= 1'b1;
    end
    q_reg <= mem_wr_flag[mem_address[15:2]] ? mem_wr_data[mem_address[15:2]]
                                            : pattern(mem_address);
  end
  assign mem_q = q_reg;

  // Read-only memory model for the second instance, three-edge read latency.
  logic [31:0] s3 [3];
  always @(posedge clock) begin
    s3[0] <= pattern(m3_address);
    s3[1] <= s3[0];
    s3[2] <= s3[1];
  end
  assign m3_q = s3[2];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q[$];
  exp_t q3[$];
  exp_t mon_e, mon3_e;

  bit          last_data;  // model of the last grant (1 = data)
  logic [31:0] last_d;     // model of the held d_rdata

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor for the main instance.
  always @(negedge clock) begin
    if (if_ack === 1'b1 || d_ack === 1'b1) begin
      if (if_ack === 1'b1 && d_ack === 1'b1) begin
        fail_now("ack_exclusive", "got both acks, want one");
      end else if (q.size() == 0) begin
        fail_now("unexpected_ack", "got an ack, want none");
      end else begin
        mon_e = q.pop_front();
        check("ack_port", 32'(d_ack), 32'(mon_e.port));
        check("ack_cycle", cyc, mon_e.cyc);
        check("ack_rdata", mon_e.port ? d_rdata : if_rdata, mon_e.rdata);
      end
    end
  end

  // Monitor for the READ_LATENCY = 3 instance.
  always @(negedge clock) begin
    if (i3_ack === 1'b1 || d3_ack === 1'b1) begin
      if (i3_ack === 1'b1 || q3.size() == 0) begin
        fail_now("lat3_unexpected_ack", "got an ack, want none");
      end else begin
        mon3_e = q3.pop_front();
        check("lat3_ack_cycle", cyc, mon3_e.cyc);
        check("lat3_rdata", d3_rdata, mon3_e.rdata);
      end
    end
  end

  // Wait for the port's ack (bounded), then drop its req.
  task automatic wait_ack(input bit port);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (port ? d_ack : if_ack) begin
        if (port) d_req = 1'b0; else if_req = 1'b0;
        return;
      end
    end
    fail_now("ack_timeout", port ? "data port got no ack in 40 cycles" : "fetch port got no ack in 40 cycles");
    if (port) d_req = 1'b0; else if_req = 1'b0;
  endtask

  // One uncontested transaction, issued while the arbiter is IDLE.
  task automatic single(input bit port, input bit wren, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [15:0] exp_addr,
                        input logic [31:0] exp_rdata, input string tag);
    exp_t e;
    e.port  = port;
    e.cyc   = cyc + 2 + LAT;
    e.rdata = (port && wren) ? last_d : exp_rdata;
    q.push_back(e);
    if (port == P_DATA) begin
      d_req = 1'b1; d_wren = wren; d_addr = addr; d_wdata = wdata;
      if (!wren) last_d = exp_rdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    last_data = port;
    @(posedge clock); #1;
    check({tag, "_addr"}, 32'(mem_address), 32'(exp_addr));
    check({tag, "_wren_access"}, 32'(mem_wren), 32'(port & wren));
    if (port & wren) check({tag, "_wdata"}, mem_data, wdata);
    @(posedge clock); #1;
    check({tag, "_wren_after"}, 32'(mem_wren), 32'd0);
    wait_ack(port);
    @(posedge clock); #1;
  endtask

  // Both ports request in the same IDLE cycle: fetch from faddr (expected
  // word fexp), load from 0x0040 (expected 0xDEADBEEF).
  task automatic conflict(input logic [15:0] faddr, input logic [31:0] fexp);
    exp_t ew, el;
    bit   win;
    win = P_DATA;
`ifdef ARB_ROUND_ROBIN_EN
    win = last_data ? P_FETCH : P_DATA;
`endif
    ew.port  = win;
    ew.cyc   = cyc + 2 + LAT;
    ew.rdata = win ? 32'hDEADBEEF : fexp;
    el.port  = !win;
    el.cyc   = cyc + 2 * (2 + LAT) + 1;
    el.rdata = win ? fexp : 32'hDEADBEEF;
    q.push_back(ew);
    q.push_back(el);
    last_data = !win;
    last_d    = 32'hDEADBEEF;
    d_req = 1'b1; d_wren = 1'b0; d_addr = 16'h0040; d_wdata = 32'h0;
    if_req = 1'b1; if_addr = faddr;
    @(posedge clock); #1;
    check("conflict_winner_addr", 32'(mem_address), win ? 32'h0040 : 32'(faddr));
    fork
      wait_ack(P_FETCH);
      wait_ack(P_DATA);
    join
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst = 1'b1; mem_busy = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wren = 1'b0; d_addr = '0; d_wdata = '0;
    i3_req = 1'b0; i3_addr = '0; d3_req = 1'b0; d3_wren = 1'b0; d3_addr = '0; d3_wdata = '0;
    last_data = 1'b1;
    last_d    = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset values
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check("rst_mem_wren", 32'(mem_wren), 32'h0);
    check("rst_acks", 32'({if_ack, d_ack}), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'h0);

    // Initialization with mem_busy held; a fetch waits through it.
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0008;
    for (int i = 0; i < 20; i++) begin
      check("init_ready_low", 32'(ready), 32'h0);
      @(posedge clock); #1;
    end
    mem_busy = 1'b0;
    check("init_ready_at_busy_fall", 32'(ready), 32'h0);
    e.port = P_FETCH; e.cyc = cyc + 4; e.rdata = 32'hC0DE_0002;
    q.push_back(e);
    last_data = P_FETCH;
    @(posedge clock); #1;
    check("init_ready_high", 32'(ready), 32'h1);
    @(posedge clock); #1;
    check("init_fetch_addr", 32'(mem_address), 32'h0008);
    wait_ack(P_FETCH);
    @(posedge clock); #1;

    // Single fetches, including the top-of-space address.
    single(P_FETCH, 1'b0, 16'h0013, 32'h0, 16'h0010, 32'hC0DE_0004, "fetch");
    single(P_FETCH, 1'b0, 16'hFFFF, 32'h0, 16'hFFFC, 32'hC0DE_3FFF, "wrap");

    // Store then load the same word (load through an unaligned address).
    single(P_DATA, 1'b1, 16'h0040, 32'hDEAD_BEEF, 16'h0040, 32'h0, "store");
    single(P_DATA, 1'b0, 16'h0043, 32'h0, 16'h0040, 32'hDEAD_BEEF, "load");

    // Reset in the WAIT cycle of a load; the held req is served after re-init.
    d_req = 1'b1; d_wren = 1'b0; d_addr = 16'h0040;
    @(posedge clock); #1;       // ACCESS
    @(posedge clock); #1;       // WAIT
    rst = 1'b1;
    @(posedge clock); #1;
    check("midrst_d_ack", 32'(d_ack), 32'h0);
    check("midrst_mem_wren", 32'(mem_wren), 32'h0);
    check("midrst_mem_address", 32'(mem_address), 32'h0);
    check("midrst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;
    last_data = P_DATA;
    last_d    = 32'h0;
    check("midrst_ready_c0", 32'(ready), 32'h0);
    @(posedge clock); #1;
    check("midrst_ready_c1", 32'(ready), 32'h0);
    @(posedge clock); #1;
    check("midrst_ready_c2", 32'(ready), 32'h1);
    e.port = P_DATA; e.cyc = cyc + 2 + LAT; e.rdata = 32'hDEAD_BEEF;
    q.push_back(e);
    last_d = 32'hDEAD_BEEF;
    wait_ack(P_DATA);
    @(posedge clock); #1;

    // Four conflicts.
    conflict(16'h0100, 32'hC0DE_0040);
    conflict(16'h0104, 32'hC0DE_0041);
    conflict(16'h0108, 32'hC0DE_0042);
    conflict(16'h010C, 32'hC0DE_0043);

    // READ_LATENCY = 3 load on the second instance.
    check("lat3_ready", 32'(ready3), 32'h1);
    e.port = P_DATA; e.cyc = cyc + 2 + LAT3; e.rdata = 32'hC0DE_0080;
    q3.push_back(e);
    d3_req = 1'b1; d3_wren = 1'b0; d3_addr = 16'h0200;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(posedge clock); #1;
        if (d3_ack) seen = 1'b1;
      end
      d3_req = 1'b0;
      if (!seen) fail_now("lat3_timeout", "got no ack in 40 cycles");
    end
    repeat (3) @(posedge clock);
    #1;

    check("sb_empty", 32'(q.size()), 32'h0);
    check("sb3_empty", 32'(q3.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
